// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared types and constants for the instruction cache.
// Holds the controller state enum, default widths and index-width helper.
package inst_cache_pkg;

    localparam int D_WIDTH_DEF = 16;
    localparam int A_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: valid/tag/data storage for the direct-mapped cache.
// Lookup is combinational; line write and flush are synchronous.
module cache_line_array
    import inst_cache_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int LINES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] lk_addr,
    output logic               hit,
    output logic [D_WIDTH-1:0] rdata,
    input  logic               we,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               flush
);

    localparam int IW = clog2(LINES);
    localparam int TW = A_WIDTH - IW;

    logic [LINES-1:0]   valid;
    logic [TW-1:0]      tags [LINES];
    logic [D_WIDTH-1:0] data [LINES];

    logic [IW-1:0] lk_idx;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] lk_tag;
    logic [TW-1:0] wr_tag;

    assign lk_idx = lk_addr[IW-1:0];
    assign lk_tag = lk_addr[A_WIDTH-1:IW];
    assign wr_idx = wr_addr[IW-1:0];
    assign wr_tag = wr_addr[A_WIDTH-1:IW];

    // Lookup: tag compare against the indexed line.
    always_comb begin
        hit   = valid[lk_idx] && (tags[lk_idx] == lk_tag);
        rdata = data[lk_idx];
    end

    // Valid bits: flush clears all, a same-edge line write still wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (flush) valid <= '0;
            if (we) valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, written with the line.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped write-through instruction cache with fixed-latency
// RAM fill. Optional hit/miss counters are enabled by ICACHE_STATS_EN.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int LINES   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic [A_WIDTH-1:0] cpu_addr,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    input  logic [D_WIDTH-1:0] cpu_wdata,
    output logic [D_WIDTH-1:0] cpu_rdata,
    output logic               odv,
    input  logic               flush,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [7:0]         hit_count,
    output logic [7:0]         miss_count
`endif
);

    state_t state;
    state_t state_nxt;

    logic [2:0]         cnt;
    logic               last;
    logic [A_WIDTH-1:0] lk_addr;
    logic               hit;
    logic [D_WIDTH-1:0] line_data;
    logic               arr_we;
    logic [D_WIDTH-1:0] arr_wdata;

    assign last    = (cnt == 3'(MEM_LAT - 1));
    assign lk_addr = (state == IDLE) ? cpu_addr : mem_addr;

    // Line update: fill completion, or write hit on the first write cycle.
    always_comb begin
        arr_we    = 1'b0;
        arr_wdata = mem_wdata;
        if (state == FILL && last) begin
            arr_we    = 1'b1;
            arr_wdata = mem_rdata;
        end else if (state == WRITE && cnt == 3'd0 && hit) begin
            arr_we    = 1'b1;
        end
    end

    cache_line_array #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .LINES   (LINES)
    ) u_lines (
        .clk     (g_clk),
        .rst     (g_clr),
        .lk_addr (lk_addr),
        .hit     (hit),
        .rdata   (line_data),
        .we      (arr_we),
        .wr_addr (mem_addr),
        .wdata   (arr_wdata),
        .flush   (flush)
    );

    // State register.
    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: write has priority over read.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cpu_wr)            state_nxt = WRITE;
                else if (cpu_rd && !hit) state_nxt = FILL;
            end
            FILL:    if (last) state_nxt = IDLE;
            WRITE:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: hits served combinationally, stall on any other request.
    always_comb begin
        odv       = 1'b0;
        cpu_rdata = '0;
        if (state == IDLE) begin
            odv = !cpu_wr && !(cpu_rd && !hit);
            if (cpu_rd && !cpu_wr && hit) cpu_rdata = line_data;
        end
    end

    // Registered RAM strobes, request capture and latency counter.
    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            cnt       <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_rd <= (state_nxt == FILL);
            mem_wr <= (state_nxt == WRITE);
            if (state != state_nxt)  cnt <= '0;
            else if (state != IDLE)  cnt <= cnt + 3'd1;
            if (state == IDLE && state_nxt != IDLE) begin
                mem_addr <= cpu_addr;
                if (cpu_wr) mem_wdata <= cpu_wdata;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic hit_ev;
    logic miss_ev;

    assign hit_ev  = (state == IDLE) && cpu_rd && !cpu_wr && hit;
    assign miss_ev = (state == IDLE) && (state_nxt == FILL);

    // Saturating hit/miss counters.
    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_ev && hit_count != 8'hFF)   hit_count  <= hit_count + 8'd1;
            if (miss_ev && miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed table, corner sequences and random traffic
// against a line-occupancy model of the cache and a RAM image.
module tb_inst_cache;

    localparam int LAT = 3;
    localparam int LN  = 4;
    localparam int F   = LAT + 1;
    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    localparam int OP_FL = 2;

    logic        g_clk = 1'b0;
    logic        g_clr;
    logic [7:0]  cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        odv;
    logic        flush;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;
`endif

    always #5 g_clk = ~g_clk;

    inst_cache #(
        .D_WIDTH (16),
        .A_WIDTH (8),
        .LINES   (LN),
        .MEM_LAT (LAT)
    ) dut (
        .g_clk     (g_clk),
        .g_clr     (g_clr),
        .cpu_addr  (cpu_addr),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .odv       (odv),
        .flush     (flush),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    // RAM: data only appears on the last cycle of a read strobe burst.
    logic [15:0] ram [256];
    int rd_age = 0;

    always @(posedge g_clk) begin
        rd_age <= mem_rd ? rd_age + 1 : 0;
        if (mem_wr) ram[mem_addr] <= mem_wdata;
    end

    assign mem_rdata = (mem_rd && rd_age == LAT - 1) ? ram[mem_addr] : 16'hDEAD;

    // Reference model state.
    logic [15:0] ref_mem [256];
    int cached [LN];
    int exp_hits;
    int exp_miss;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ram_init(input int a);
        logic [15:0] v;
        v = 16'(a) * 16'h0101;
        return v ^ 16'h1234;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LN; i++) cached[i] = -1;
    endtask

    task automatic model_step(input int op, input logic [7:0] a, input logic [15:0] wd,
                              input int fa, output int e_stall, output logic [15:0] e_data);
        int idx;
        idx = int'(a) % LN;
        e_stall = 0;
        e_data = '0;
        if (op == OP_FL) begin
            model_clear();
        end else if (op == OP_WR) begin
            ref_mem[a] = wd;
            e_stall = F;
        end else begin
            e_data = ref_mem[a];
            exp_hits++;
            if (cached[idx] != int'(a)) begin
                e_stall = F;
                exp_miss++;
                if (fa >= 0) model_clear();
                cached[idx] = int'(a);
            end
        end
    endtask

    task automatic do_op(input int op, input logic [7:0] a, input logic [15:0] wd,
                         input int fa, output int stall, output logic [15:0] data,
                         output int rdc, output int wrc, output logic [7:0] maddr,
                         output logic [15:0] mwd, output bit tmo);
        stall = 0; data = '0; rdc = 0; wrc = 0;
        maddr = '0; mwd = '0; tmo = 1'b0;
        @(posedge g_clk); #1;
        if (op == OP_FL) begin
            flush = 1'b1;
            @(negedge g_clk);
            if (!odv) stall++;
            @(posedge g_clk); #1;
            flush = 1'b0;
        end else if (op == OP_WR) begin
            cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = wd;
            for (int c = 0; c <= LAT + 1; c++) begin
                if (c == LAT + 1) begin
                    @(posedge g_clk); #1;
                    cpu_wr = 1'b0;
                end
                @(negedge g_clk);
                if (!odv) stall++;
                if (mem_rd) rdc++;
                if (mem_wr) begin wrc++; maddr = mem_addr; mwd = mem_wdata; end
            end
        end else begin
            cpu_rd = 1'b1; cpu_addr = a;
            tmo = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge g_clk);
                if (mem_rd) begin rdc++; maddr = mem_addr; end
                if (mem_wr) wrc++;
                if (odv) begin data = cpu_rdata; tmo = 1'b0; break; end
                stall++;
                flush = (c == fa);
            end
            flush = 1'b0;
            @(posedge g_clk); #1;
            cpu_rd = 1'b0;
        end
    endtask

    task automatic apply(input string nm, input int op, input logic [7:0] a,
                         input logic [15:0] wd, input int fa,
                         input int e_stall, input logic [15:0] e_data);
        int st, rc, wc;
        logic [15:0] d, mw;
        logic [7:0] ma;
        bit tmo;
        do_op(op, a, wd, fa, st, d, rc, wc, ma, mw, tmo);
        chk({nm, ".stall"}, st, e_stall);
        if (op == OP_RD) begin
            chk({nm, ".tmo"}, tmo, 0);
            chk({nm, ".data"}, d, e_data);
            chk({nm, ".mem_rd_cyc"}, rc, (e_stall == 0) ? 0 : LAT);
            chk({nm, ".mem_wr_cyc"}, wc, 0);
            if (e_stall != 0) chk({nm, ".mem_addr"}, ma, a);
        end else if (op == OP_WR) begin
            chk({nm, ".mem_wr_cyc"}, wc, LAT);
            chk({nm, ".mem_rd_cyc"}, rc, 0);
            chk({nm, ".mem_addr"}, ma, a);
            chk({nm, ".mem_wdata"}, mw, wd);
        end
    endtask

    task automatic run_model(input string nm, input int op, input logic [7:0] a,
                             input logic [15:0] wd, input int fa);
        int es;
        logic [15:0] ed;
        model_step(op, a, wd, fa, es, ed);
        apply(nm, op, a, wd, fa, es, ed);
    endtask

    typedef struct {
        int          op;
        logic [7:0]  a;
        logic [15:0] wd;
        int          e_stall;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        int es;
        logic [15:0] ed;

        tbl[0]  = '{OP_RD, 8'h00, 16'h0000, F, 16'h1234};
        tbl[1]  = '{OP_RD, 8'h00, 16'h0000, 0, 16'h1234};
        tbl[2]  = '{OP_RD, 8'h04, 16'h0000, F, 16'h1630};
        tbl[3]  = '{OP_WR, 8'h04, 16'h5555, F, 16'h0000};
        tbl[4]  = '{OP_RD, 8'h04, 16'h0000, 0, 16'h5555};
        tbl[5]  = '{OP_RD, 8'h00, 16'h0000, F, 16'h1234};
        tbl[6]  = '{OP_WR, 8'h09, 16'hA9A9, F, 16'h0000};
        tbl[7]  = '{OP_RD, 8'h09, 16'h0000, F, 16'hA9A9};
        tbl[8]  = '{OP_RD, 8'h01, 16'h0000, F, 16'h1335};
        tbl[9]  = '{OP_RD, 8'h02, 16'h0000, F, 16'h1036};
        tbl[10] = '{OP_RD, 8'h03, 16'h0000, F, 16'h1137};
        tbl[11] = '{OP_RD, 8'h01, 16'h0000, 0, 16'h1335};
        tbl[12] = '{OP_FL, 8'h00, 16'h0000, 0, 16'h0000};
        tbl[13] = '{OP_RD, 8'h00, 16'h0000, F, 16'h1234};
        tbl[14] = '{OP_RD, 8'h01, 16'h0000, F, 16'h1335};
        tbl[15] = '{OP_RD, 8'h02, 16'h0000, F, 16'h1036};
        tbl[16] = '{OP_RD, 8'h03, 16'h0000, F, 16'h1137};
        tbl[17] = '{OP_RD, 8'h03, 16'h0000, 0, 16'h1137};

        for (int i = 0; i < 256; i++) begin
            ram[i] = ram_init(i);
            ref_mem[i] = ram_init(i);
        end
        model_clear();
        exp_hits = 0;
        exp_miss = 0;

        g_clr = 1'b1;
        cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_wdata = '0; flush = 1'b0;
        #12;
        chk("rst.odv", odv, 1);
        chk("rst.cpu_rdata", cpu_rdata, 0);
        chk("rst.mem_rd", mem_rd, 0);
        chk("rst.mem_wr", mem_wr, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
`ifdef ICACHE_STATS_EN
        chk("rst.hit_count", hit_count, 0);
        chk("rst.miss_count", miss_count, 0);
`endif
        @(negedge g_clk);
        g_clr = 1'b0;

        for (int i = 0; i < 18; i++) begin
            model_step(tbl[i].op, tbl[i].a, tbl[i].wd, -1, es, ed);
            apply($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].wd, -1,
                  tbl[i].e_stall, tbl[i].e_data);
        end

        // Flush on the last fill cycle: the filled line survives.
        run_model("flfill.miss", OP_RD, 8'h06, 16'h0, LAT);
        run_model("flfill.hit", OP_RD, 8'h06, 16'h0, -1);
        run_model("flfill.other", OP_RD, 8'h03, 16'h0, -1);

        // Reset in the middle of a fill aborts it.
        @(posedge g_clk); #1;
        cpu_rd = 1'b1; cpu_addr = 8'h0A;
        repeat (3) @(negedge g_clk);
        chk("rstfill.mem_rd_before", mem_rd, 1);
        g_clr = 1'b1;
        cpu_rd = 1'b0;
        #1;
        chk("rstfill.mem_rd", mem_rd, 0);
        chk("rstfill.odv", odv, 1);
        chk("rstfill.cpu_rdata", cpu_rdata, 0);
        @(negedge g_clk);
        g_clr = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_miss = 0;
        run_model("rstfill.refetch", OP_RD, 8'h0A, 16'h0, -1);
        run_model("rstfill.old", OP_RD, 8'h06, 16'h0, -1);

        for (int i = 0; i < 200; i++) begin
            int r;
            logic [7:0] a;
            logic [15:0] wd;
            r = $urandom_range(0, 9);
            a = 8'($urandom_range(0, 15));
            wd = 16'($urandom);
            if (r < 7)      run_model($sformatf("rnd%0d", i), OP_RD, a, wd, -1);
            else if (r < 9) run_model($sformatf("rnd%0d", i), OP_WR, a, wd, -1);
            else            run_model($sformatf("rnd%0d", i), OP_FL, a, wd, -1);
        end

`ifdef ICACHE_STATS_EN
        chk("stats.hits", hit_count, (exp_hits > 255) ? 255 : exp_hits);
        chk("stats.miss", miss_count, (exp_miss > 255) ? 255 : exp_miss);
        @(negedge g_clk);
        g_clr = 1'b1;
        @(negedge g_clk);
        g_clr = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_miss = 0;
        for (int i = 0; i < 300; i++) begin
            model_step(OP_RD, 8'h01, 16'h0, -1, es, ed);
            apply("sat", OP_RD, 8'h01, 16'h0, -1, es, ed);
        end
        chk("sat.hit_count", hit_count, 255);
        chk("sat.miss_count", miss_count, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
